debug_ring_link: RTL

//  Two-channel buffered link stage between debug ring segments, e.g. ext_out of one

---
 rtl/debug_ring_link_pkg.sv | 9 +
 rtl/dii_package.sv | 10 +
 rtl/debug_ring_link_if.sv | 35 +++
 rtl/debug_ring_link_fifo.sv | 78 +++++++
 rtl/debug_ring_link.sv | 27 ++
 5 files changed

// File: rtl/debug_ring_link_pkg.sv
// Shared constants for the two-channel debug ring link stage.
package debug_ring_link_pkg;

    localparam int unsigned NumChannels = 2;
    localparam int unsigned PktCntW     = 16;
    // Stored flit payload: {last, data[15:0]}
    localparam int unsigned FlitW       = 17;

endpackage

// File: rtl/dii_package.sv
// Debug interconnect flit type shared by all debug ring blocks.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/debug_ring_link_if.sv
// Bundle of per-channel flit, handshake and debug signals crossing the link stage.
interface debug_ring_link_if #(
    parameter int unsigned DEPTH = 4
) ();
    import dii_package::*;
    import debug_ring_link_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);

    dii_flit [NumChannels-1:0]              link_in;
    logic    [NumChannels-1:0]              link_in_ready;
    dii_flit [NumChannels-1:0]              link_out;
    logic    [NumChannels-1:0]              link_out_ready;
    logic    [NumChannels-1:0][CW-1:0]      fill_level;
    logic    [NumChannels-1:0][PktCntW-1:0] pkt_count;

    modport master (
        output link_in,
        output link_out_ready,
        input  link_in_ready,
        input  link_out,
        input  fill_level,
        input  pkt_count
    );

    modport slave (
        input  link_in,
        input  link_out_ready,
        output link_in_ready,
        output link_out,
        output fill_level,
        output pkt_count
    );

endinterface

// File: rtl/debug_ring_link_fifo.sv
// One link channel: flit FIFO with registered upstream ready and a delivered-packet counter.
module debug_ring_link_fifo
    import dii_package::*;
    import debug_ring_link_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  dii_flit            in_i,
    output logic               in_ready_o,
    output dii_flit            out_o,
    input  logic               out_ready_i,
    output logic [CW-1:0]      fill_level_o,
    output logic [PktCntW-1:0] pkt_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0][FlitW-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        ready_q, ready_d;
    logic [PktCntW-1:0]          pkt_q, pkt_d;
    logic                        push, pop;

    always_comb begin
        push     = in_i.valid & ready_q;
        pop      = (count_q != '0) & out_ready_i;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pkt_d    = pkt_q;

        if (push) begin
            mem_d[wr_ptr_q] = {in_i.last, in_i.data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (mem_q[rd_ptr_q][FlitW-1]) begin
                pkt_d = pkt_q + PktCntW'(1);
            end
        end

        count_d = count_q + CW'(push) - CW'(pop);
        // Ready is decided from next-cycle occupancy so out_ready never reaches in_ready.
        ready_d = (count_d < CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            pkt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            pkt_q    <= pkt_d;
        end
    end

    assign in_ready_o   = ready_q;
    assign out_o.valid  = (count_q != '0);
    assign out_o.last   = mem_q[rd_ptr_q][FlitW-1];
    assign out_o.data   = mem_q[rd_ptr_q][15:0];
    assign fill_level_o = count_q;
    assign pkt_count_o  = pkt_q;

endmodule

// File: rtl/debug_ring_link.sv
// Two independent buffered debug ring channels, breaking the ready path between segments.
module debug_ring_link
    import debug_ring_link_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    debug_ring_link_if.slave   link
);

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        debug_ring_link_fifo #(
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_i        (link.link_in[c]),
            .in_ready_o  (link.link_in_ready[c]),
            .out_o       (link.link_out[c]),
            .out_ready_i (link.link_out_ready[c]),
            .fill_level_o(link.fill_level[c]),
            .pkt_count_o (link.pkt_count[c])
        );
    end

endmodule
